bram_write_arbiter: RTL and testbench
=====================================

Name: bram_write_arbiter

Overview:
- Shares one BRAM write port among NUM_REQ tile producers, e.g. parallel output-drain lanes of the systolic array.
- Grants one producer per tile and writes NUM_WRITES_PER_TILE consecutive words for that tile.
- Tiles land contiguously in BRAM, in grant order, from a shared tile pointer.
- Sits between the datapath drain lanes and the output-buffer BRAM.

Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_WRITES_PER_TILE, 2, BRAM words per tile (>=1).
- ADDR_WIDTH, 11, BRAM address width.
- DATA_WIDTH, 256, BRAM word width.
- TILE_PTR_WIDTH, 9, tile pointer width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester write request, level.
- wr_data  in  NUM_REQ*DATA_WIDTH  per-requester word; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- reset_addr_counter  in  1  pulse; clears tile pointer.
- grant  out  NUM_REQ  one-hot owner of the port.
- done  out  NUM_REQ  one-cycle pulse to owner when its tile is written.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_we  out  1  BRAM write enable (also enable).
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, done=0, bram_we=0, bram_addr=0, bram_din=0, busy=0.
  - tile_ptr=0, write_offset=0.
  - rr_last=NUM_REQ-1, so req[0] has first priority.
- States: IDLE, WRITING, DONE.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - Register winner g, latch tile_base = tile_ptr*NUM_WRITES_PER_TILE, go to WRITING.
  - If no req bit is high, stay in IDLE.
- WRITING:
  - grant[g]=1, bram_we=1, bram_addr = tile_base + write_offset, truncated to ADDR_WIDTH (wraps mod 2^ADDR_WIDTH).
  - bram_din = wr_data slice g, combinational in the same cycle. The requester must present word k while write_offset==k.
  - write_offset increments each cycle. At NUM_WRITES_PER_TILE-1, go to DONE and clear write_offset.
- DONE:
  - grant[g]=1, done[g]=1, bram_we=0.
  - rr_last<=g; tile_ptr<=tile_ptr+1 (wraps mod 2^TILE_PTR_WIDTH); go to IDLE.
- Timing:
  - req sampled in IDLE at cycle T -> WRITING T+1..T+W, DONE at T+W+1, IDLE at T+W+2.
  - W = NUM_WRITES_PER_TILE.
  - Back-to-back tiles: one write burst per W+2 cycles.
- Handshake:
  - req must stay high until done.
  - req still high in the IDLE cycle after done is treated as a new request.
  - Dropping req mid-tile is ignored; the tile completes and done still pulses.
- grant, done, bram_we, bram_addr are decoded from registered state, offset and base; no combinational path from req.
- reset_addr_counter:
  - tile_ptr<=0 at the next edge; this takes priority over the DONE increment.
  - In WRITING, the current tile keeps its latched tile_base; only the next tile starts at address 0.
- Async reset mid-tile: immediately returns all outputs to reset values. No done is issued and the partial tile is abandoned.
- Requests from a non-owner during WRITING/DONE are held off; they are not lost because they are level signals.

Optional Feature:
- Macro: WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set index wins in IDLE; rr_last is unused.
- Undefined: round-robin as specified above.

Test Plan:
- Single requester: req[1]=1 with words A,B; W=2 -> we=1 at addr 0,1 with din A,B; done[1] pulse at T+3; next tile at addr 2,3.
- Simultaneous requesters: req=4'b1111 held and dropped after each done -> grant order 0,1,2,3,0; tile addresses 0,2,4,6,8.
- reset_addr_counter coincident with DONE of tile at addr 6,7 -> next tile writes addr 0,1.
- Address wrap: ADDR_WIDTH=3, W=2, five tiles -> addresses 0..7 then 0,1 again; tile_ptr reaches 4.
- Async reset: rst_n low during the second WRITING cycle -> we=0, grant=0, done never pulses; after release, req[2] is granted at tile address 0.
- Fixed priority: WR_ARB_FIXED_PRIO_EN defined, req=4'b0110 held -> requester 1 granted repeatedly and requester 2 starved.

Source files
------------

// File: rtl/bram_write_arbiter_if.sv
// Bus bundle between the tile producers and the shared BRAM write port.
// The master drives requests and data; the slave is the arbiter.
interface bram_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 11
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic                          reset_addr_counter;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0]         bram_din;
  logic                          bram_we;
  logic                          busy;

  modport master (
    output req, wr_data, reset_addr_counter,
    input  grant, done, bram_addr, bram_din, bram_we, busy
  );

  modport slave (
    input  req, wr_data, reset_addr_counter,
    output grant, done, bram_addr, bram_din, bram_we, busy
  );
endinterface

// File: rtl/bram_write_arbiter.sv
// Shares one BRAM write port among NUM_REQ tile producers; tiles land contiguously in grant order.
// Round-robin by default; define WR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module bram_write_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int NUM_WRITES_PER_TILE = 2,
  parameter int ADDR_WIDTH          = 11,
  parameter int DATA_WIDTH          = 256,
  parameter int TILE_PTR_WIDTH      = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  bram_write_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OFF_W = (NUM_WRITES_PER_TILE > 1) ? $clog2(NUM_WRITES_PER_TILE) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NUM_WRITES_PER_TILE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [IDX_W-1:0]      owner_r, owner_s;
  logic [ADDR_WIDTH-1:0] tile_base_r, tile_base_s;
  logic [OFF_W-1:0]      write_offset_r, write_offset_s;
  logic [TILE_PTR_WIDTH-1:0] tile_ptr_r, tile_ptr_s;

  logic                  found_s;
  logic [IDX_W-1:0]      win_s;

  logic [NUM_REQ-1:0]    grant_r, grant_s;
  logic [NUM_REQ-1:0]    done_r, done_s;
  logic                  bram_we_r, bram_we_s;
  logic [ADDR_WIDTH-1:0] bram_addr_r, bram_addr_s;
  logic                  busy_r, busy_s;
  logic [DATA_WIDTH-1:0] bram_din_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      vec[i] = (IDX_W'(i) == idx);
    end
    return vec;
  endfunction

`ifdef WR_ARB_FIXED_PRIO_EN
  // Fixed priority: scanning downwards leaves the lowest set index as winner.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDX_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      found_s = found_s | bus.req[IDX_W'(i)];
      win_s   = bus.req[IDX_W'(i)] ? IDX_W'(i) : win_s;
    end
  end
`else
  logic [IDX_W-1:0] rr_last_r, rr_last_s;

  // Round-robin: scan offsets high to low so the nearest one after rr_last wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDX_W{1'b0}};
    for (int i = NUM_REQ; i >= 1; i--) begin
      found_s = found_s | bus.req[IDX_W'((int'(rr_last_r) + i) % NUM_REQ)];
      win_s   = bus.req[IDX_W'((int'(rr_last_r) + i) % NUM_REQ)]
              ? IDX_W'((int'(rr_last_r) + i) % NUM_REQ) : win_s;
    end
  end

  // Last owner advances only once its tile is finished.
  always_comb begin
    rr_last_s = (state_r == ST_DONE) ? owner_r : rr_last_r;
  end

  // Round-robin pointer register; reset gives requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= IDX_W'(NUM_REQ - 1);
    end else begin
      rr_last_r <= rr_last_s;
    end
  end
`endif

  // Next-state and tile bookkeeping.
  always_comb begin
    state_s        = state_r;
    owner_s        = owner_r;
    tile_base_s    = tile_base_r;
    write_offset_s = write_offset_r;
    tile_ptr_s     = tile_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s        = ST_WRITING;
          owner_s        = win_s;
          tile_base_s    = ADDR_WIDTH'(tile_ptr_r) * ADDR_WIDTH'(NUM_WRITES_PER_TILE);
          write_offset_s = {OFF_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITING: begin
        if (write_offset_r == LAST_OFF) begin
          state_s        = ST_DONE;
          write_offset_s = {OFF_W{1'b0}};
        end else begin
          write_offset_s = write_offset_r + OFF_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        tile_ptr_s = tile_ptr_r + TILE_PTR_WIDTH'(1'b1);
      end
      default: begin
        state_s        = ST_IDLE;
        write_offset_s = {OFF_W{1'b0}};
      end
    endcase
    // A pointer clear wins over the end-of-tile increment.
    tile_ptr_s = bus.reset_addr_counter ? {TILE_PTR_WIDTH{1'b0}} : tile_ptr_s;
  end

  // Port controls for the coming cycle, decoded from the next state only.
  always_comb begin
    grant_s     = {NUM_REQ{1'b0}};
    done_s      = {NUM_REQ{1'b0}};
    bram_we_s   = 1'b0;
    bram_addr_s = {ADDR_WIDTH{1'b0}};
    busy_s      = (state_s != ST_IDLE);
    case (state_s)
      ST_WRITING: begin
        grant_s     = onehot(owner_s);
        bram_we_s   = 1'b1;
        bram_addr_s = tile_base_s + ADDR_WIDTH'(write_offset_s);
      end
      ST_DONE: begin
        grant_s = onehot(owner_s);
        done_s  = onehot(owner_s);
      end
      default: begin
        bram_we_s = 1'b0;
      end
    endcase
  end

  // FSM and tile bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      owner_r        <= {IDX_W{1'b0}};
      tile_base_r    <= {ADDR_WIDTH{1'b0}};
      write_offset_r <= {OFF_W{1'b0}};
      tile_ptr_r     <= {TILE_PTR_WIDTH{1'b0}};
    end else begin
      state_r        <= state_s;
      owner_r        <= owner_s;
      tile_base_r    <= tile_base_s;
      write_offset_r <= write_offset_s;
      tile_ptr_r     <= tile_ptr_s;
    end
  end

  // Output registers; async reset drops an in-flight tile without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r     <= {NUM_REQ{1'b0}};
      done_r      <= {NUM_REQ{1'b0}};
      bram_we_r   <= 1'b0;
      bram_addr_r <= {ADDR_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      grant_r     <= grant_s;
      done_r      <= done_s;
      bram_we_r   <= bram_we_s;
      bram_addr_r <= bram_addr_s;
      busy_r      <= busy_s;
    end
  end

  // Write data passes straight through from the owner so word k meets offset k.
  always_comb begin
    bram_din_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      bram_din_s = (bram_we_r && (owner_r == IDX_W'(i)))
                 ? bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH] : bram_din_s;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.bram_we   = bram_we_r;
  assign bus.bram_addr = bram_addr_r;
  assign bus.bram_din  = bram_din_s;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_bram_write_arbiter.sv
// Scoreboard bench for bram_write_arbiter: expected writes/done pulses are queued when a
// scenario starts and popped by a negedge monitor as the port produces them.
module tb_bram_write_arbiter;
  localparam int NR = 4;
  localparam int W  = 2;
  localparam int AW = 11;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            owner;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;
  int   seq    = 0;
  int   wcnt [NR];
  wr_t  exp_wr[$];
  int   exp_done[$];

  bram_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  bram_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(3))  bus_w ();

  bram_write_arbiter #(.NUM_REQ(NR), .NUM_WRITES_PER_TILE(W), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .TILE_PTR_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  bram_write_arbiter #(.NUM_REQ(NR), .NUM_WRITES_PER_TILE(W), .ADDR_WIDTH(3),
                       .DATA_WIDTH(DW), .TILE_PTR_WIDTH(9)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int i, input int s, input int k);
    return {8'(i), 8'(s), 16'(k)};
  endfunction

  // Producers step to their next word after each granted write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) wcnt[i] <= 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (bus.done[i]) wcnt[i] <= 0;
        else if (bus.grant[i] && bus.bram_we) wcnt[i] <= wcnt[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) bus.wr_data[i*DW +: DW] = word_of(i, seq, wcnt[i]);
  end

  always @(negedge clk) begin : sb_monitor
    wr_t e;
    int  d;
    if (bus.bram_we === 1'b1) begin
      n_run++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: unexpected write addr=%0d din=%h", bus.bram_addr, bus.bram_din);
      end else begin
        e = exp_wr.pop_front();
        if (bus.bram_addr !== e.addr || bus.bram_din !== e.data || bus.grant !== (4'b0001 << e.owner)) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0d din=%h grant=%b, expected addr=%0d din=%h owner=%0d",
                   bus.bram_addr, bus.bram_din, bus.grant, e.addr, e.data, e.owner);
        end
      end
    end
    if (bus.done !== 4'b0000) begin
      n_run++;
      if (exp_done.size() == 0) begin
        n_fail++;
        $display("FAIL sb_done: unexpected done=%b", bus.done);
      end else begin
        d = exp_done.pop_front();
        if (bus.done !== (4'b0001 << d)) begin
          n_fail++;
          $display("FAIL sb_done: got done=%b, expected owner %0d", bus.done, d);
        end
      end
    end
  end

  task automatic push_tile(input int owner, input int base);
    wr_t e;
    for (int k = 0; k < W; k++) begin
      e.addr  = AW'(base + k);
      e.data  = word_of(owner, seq, k);
      e.owner = owner;
      exp_wr.push_back(e);
    end
    exp_done.push_back(owner);
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    bus.reset_addr_counter = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_run++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, bus.busy, budget);
    end
  endtask

  task automatic check_drained(input string name);
    n_run++;
    if (exp_wr.size() != 0 || exp_done.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d writes and %0d done pulses outstanding, expected 0",
               name, exp_wr.size(), exp_done.size());
    end
  endtask

  // Holds req_val until n_tiles done pulses; pulses reset_addr_counter during done number rac_at.
  task automatic run_tiles(input logic [NR-1:0] req_val, input int n_tiles, input int rac_at,
                           input int budget, input string name);
    int cnt = 0;
    int cyc = 0;
    bus.req = req_val;
    while (cnt < n_tiles && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.reset_addr_counter = 1'b0;
      if (bus.done !== 4'b0000) begin
        cnt++;
        if (cnt == rac_at) bus.reset_addr_counter = 1'b1;
        if (cnt == n_tiles) bus.req = 4'b0000;
      end
    end
    @(negedge clk);
    bus.reset_addr_counter = 1'b0;
    bus.req = 4'b0000;
    n_run++;
    if (cnt != n_tiles) begin
      n_fail++;
      $display("FAIL %s_tiles: saw %0d done pulses, expected %0d", name, cnt, n_tiles);
    end
    wait_idle(20, name);
    check_drained(name);
  endtask

  task automatic test_reset();
    bus.req = 4'b0000;
    bus.reset_addr_counter = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_run += 6;
    if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
    if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", bus.done); end
    if (bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.bram_we); end
    if (bus.bram_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.bram_addr); end
    if (bus.bram_din !== 32'd0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", bus.bram_din); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    seq = 1;
    push_tile(1, 0);
    push_tile(1, 2);
    bus.req = 4'b0010;
    @(negedge clk);
    n_run++;
    if (bus.bram_we !== 1'b1 || bus.bram_addr !== 11'd0) begin
      n_fail++; $display("FAIL single_t1: got we=%b addr=%0d expected we=1 addr=0", bus.bram_we, bus.bram_addr);
    end
    @(negedge clk);
    n_run++;
    if (bus.bram_we !== 1'b1 || bus.bram_addr !== 11'd1) begin
      n_fail++; $display("FAIL single_t2: got we=%b addr=%0d expected we=1 addr=1", bus.bram_we, bus.bram_addr);
    end
    @(negedge clk);
    n_run++;
    if (bus.done !== 4'b0010 || bus.bram_we !== 1'b0) begin
      n_fail++; $display("FAIL single_t3: got done=%b we=%b expected done=0010 we=0", bus.done, bus.bram_we);
    end
    @(negedge clk);
    n_run++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_gap: got busy=%b expected 0", bus.busy);
    end
    @(negedge clk);
    n_run++;
    if (bus.grant !== 4'b0010 || bus.bram_addr !== 11'd2) begin
      n_fail++; $display("FAIL single_next: got grant=%b addr=%0d expected 0010 addr=2", bus.grant, bus.bram_addr);
    end
    bus.req = 4'b0000;
    wait_idle(20, "single");
    check_drained("single");
  endtask

  task automatic test_simultaneous();
    do_reset();
    seq = 2;
    push_tile(0, 0);
    push_tile(1, 2);
    push_tile(2, 4);
    push_tile(3, 6);
    push_tile(0, 8);
    run_tiles(4'b1111, 5, 0, 80, "simul");
  endtask

  task automatic test_rac_done();
    @(negedge clk);
    bus.reset_addr_counter = 1'b1;
    @(negedge clk);
    bus.reset_addr_counter = 1'b0;
    seq = 3;
    push_tile(3, 0);
    push_tile(3, 2);
    push_tile(3, 4);
    push_tile(3, 6);
    push_tile(3, 0);
    run_tiles(4'b1000, 5, 4, 80, "rac_done");
  endtask

  task automatic test_async_reset();
    wr_t e;
    do_reset();
    seq = 4;
    e.addr  = 11'd0;
    e.data  = word_of(2, 4, 0);
    e.owner = 2;
    exp_wr.push_back(e);
    bus.req = 4'b0100;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.bram_we !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_outputs: got we=%b grant=%b busy=%b expected 0 0000 0", bus.bram_we, bus.grant, bus.busy);
    end
    repeat (3) begin
      @(negedge clk);
      n_run++;
      if (bus.done !== 4'b0000) begin
        n_fail++; $display("FAIL async_done: got done=%b expected 0000", bus.done);
      end
    end
    check_drained("async_partial");
    push_tile(2, 0);
    rst_n = 1'b1;
    run_tiles(4'b0100, 1, 0, 20, "async_after");
  endtask

  task automatic test_wrap();
    int nw  = 0;
    int nd  = 0;
    int cyc = 0;
    bus_w.req = 4'b0001;
    while (nd < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_w.bram_we === 1'b1) begin
        n_run++;
        if (nw >= 10 || bus_w.bram_addr !== 3'(nw % 8)) begin
          n_fail++; $display("FAIL wrap_addr: write %0d got addr=%0d expected %0d", nw, bus_w.bram_addr, nw % 8);
        end
        if (nw == 8) begin
          n_run++;
          if (dut_w.tile_ptr_r !== 9'd4) begin
            n_fail++; $display("FAIL wrap_ptr: got tile_ptr=%0d expected 4", dut_w.tile_ptr_r);
          end
        end
        nw++;
      end
      if (bus_w.done !== 4'b0000) begin
        nd++;
        if (nd == 5) bus_w.req = 4'b0000;
      end
    end
    bus_w.req = 4'b0000;
    n_run++;
    if (nw != 10) begin
      n_fail++; $display("FAIL wrap_count: got %0d writes expected 10", nw);
    end
  endtask

  task automatic test_priority();
    do_reset();
    seq = 5;
`ifdef WR_ARB_FIXED_PRIO_EN
    push_tile(1, 0);
    push_tile(1, 2);
    push_tile(1, 4);
`else
    push_tile(1, 0);
    push_tile(2, 2);
    push_tile(1, 4);
`endif
    run_tiles(4'b0110, 3, 0, 60, "priority");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = 4'b0000;
    bus.reset_addr_counter = 1'b0;
    bus_w.req = 4'b0000;
    bus_w.wr_data = '0;
    bus_w.reset_addr_counter = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_rac_done();
    test_async_reset();
    test_wrap();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
